// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master byte path.
// Mode 0 only: SCLK idles low, data is launched on falling edges and sampled on rising edges.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_t;

  localparam logic CPOL      = 1'b0;
  localparam logic CPHA      = 1'b0;
  localparam logic SCLK_IDLE = CPOL;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_CS_HOLD = 8;
  localparam int DEF_CS_LEAD = 2;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV enabled cycles and flags the edge one cycle ahead.
// Disabling it parks sclk at its idle level with the divider cleared.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap      = en && (div_cnt == DIV_LAST);
  assign rise_tick = wrap && (sclk == SCLK_IDLE);
  assign fall_tick = wrap && (sclk != SCLK_IDLE);

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      div_cnt <= '0;
      sclk    <= SCLK_IDLE;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master byte engine: takes bytes over valid/ready, shifts them out MSB-first
// and returns the captured MISO byte; cs_n stays low across bytes until an idle gap expires.
//
// state | meaning
// IDLE  | cs_n high, waiting for a byte
// LEAD  | cs_n low, sclk parked, CS_LEAD cycles of setup before the first edge
// SHIFT | sclk running, 8 bits exchanged
// HOLD  | cs_n still low, accepts the next byte or times out after CS_HOLD cycles
module spi_byte_shifter
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_HOLD = DEF_CS_HOLD,
  parameter int CS_LEAD = DEF_CS_LEAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_n,
  output logic       busy
);

  localparam int LW = $clog2(CS_LEAD + 1);
  localparam int IW = $clog2(CS_HOLD + 1);
  localparam logic [LW-1:0] LEAD_LAST = LW'(CS_LEAD - 1);
  localparam logic [IW-1:0] HOLD_LAST = IW'(CS_HOLD - 1);

  spi_state_t    state, state_nxt;
  logic [7:0]    tx_sr, rx_sr;
  logic [2:0]    bit_cnt;
  logic [LW-1:0] lead_cnt;
  logic [IW-1:0] idle_cnt;
  logic          xfer, last_fall;
  logic          rise_tick, fall_tick;

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (state == ST_SHIFT),
    .sclk      (spi_sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign last_fall = fall_tick && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    spi_cs_n  = 1'b0;
    busy      = 1'b1;
    spi_mosi  = tx_sr[7];
    xfer      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        spi_cs_n = 1'b1;
        busy     = 1'b0;
        spi_mosi = MOSI_IDLE;
        xfer     = in_valid;
        if (xfer) state_nxt = ST_LEAD;
      end
      ST_LEAD: begin
        if (lead_cnt == LEAD_LAST) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_fall) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        in_ready = 1'b1;
        xfer     = in_valid;
        // A byte offered on the timeout cycle keeps cs_n low and skips the lead-in.
        if (xfer)                         state_nxt = ST_SHIFT;
        else if (idle_cnt == HOLD_LAST)   state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      lead_cnt  <= '0;
      idle_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (xfer) begin
            tx_sr    <= in_data;
            bit_cnt  <= '0;
            lead_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        ST_LEAD: begin
          if (lead_cnt != LEAD_LAST) lead_cnt <= lead_cnt + LW'(1);
        end
        ST_SHIFT: begin
          if (rise_tick) rx_sr <= {rx_sr[6:0], spi_miso};
          if (fall_tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              tx_sr <= {tx_sr[6:0], 1'b0};
            end else begin
              out_data  <= rx_sr;
              out_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            tx_sr    <= in_data;
            idle_cnt <= '0;
          end else if (idle_cnt != HOLD_LAST) begin
            idle_cnt <= idle_cnt + IW'(1);
          end else begin
            idle_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Self-checking bench for spi_byte_shifter: default build (4/8/2) plus a fast 1/1/1 build.
module tb_spi_byte_shifter;

  localparam int CLK_DIV = 4;
  localparam int CS_HOLD = 8;
  localparam int CS_LEAD = 2;
  localparam int T_FIRST = CS_LEAD + 16 * CLK_DIV;
  localparam int T_NEXT  = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, out_valid, spi_sclk, spi_mosi, spi_miso, spi_cs_n, busy;
  logic [7:0] out_data;
  logic [1:0] miso_mode = 2'd0;
  logic       miso_const = 1'b0;
  logic       miso_rand = 1'b0;

  logic [7:0] b_in_data = '0;
  logic       b_in_valid = 1'b0;
  logic       b_in_ready, b_out_valid, b_sclk, b_mosi, b_miso, b_cs_n, b_busy;
  logic [7:0] b_out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign spi_miso = (miso_mode == 2'd0) ? spi_mosi :
                    (miso_mode == 2'd1) ? miso_const : miso_rand;
  assign b_miso   = b_mosi;

  always @(negedge clk) miso_rand <= 1'($urandom_range(0, 1));

  spi_byte_shifter #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD), .CS_LEAD(CS_LEAD)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n), .busy(busy)
  );

  spi_byte_shifter #(.CLK_DIV(1), .CS_HOLD(1), .CS_LEAD(1)) u_dut_fast (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
    .spi_miso(b_miso), .spi_cs_n(b_cs_n), .busy(b_busy)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: bytes offered, and the bus bits seen at every SCLK rising edge.
  logic [7:0] tx_q[$];
  bit         mosi_q[$];
  bit         miso_q[$];
  logic       prev_sclk = 1'b0;

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      tx_q.delete();
      mosi_q.delete();
      miso_q.delete();
      prev_sclk = 1'b0;
    end else begin
      if (spi_sclk && !prev_sclk) begin
        mosi_q.push_back(spi_mosi);
        miso_q.push_back(spi_miso);
        chk("cs_low_on_rise", spi_cs_n, 0);
      end
      if (out_valid) begin
        int rx_v, tx_v, nbits;
        rx_v = 0;
        tx_v = 0;
        nbits = mosi_q.size();
        while (mosi_q.size() > 0) begin
          tx_v = (tx_v * 2 + int'(mosi_q.pop_front())) % 256;
          rx_v = (rx_v * 2 + int'(miso_q.pop_front())) % 256;
        end
        chk("rises_per_byte", nbits, 8);
        chk("rx_byte_vs_bus", out_data, rx_v);
        if (tx_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
        else chk("mosi_byte", tx_v, tx_q.pop_front());
      end
      prev_sclk = spi_sclk;
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 1000) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_seen", in_ready, 1);
    tx_q.push_back(b);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int n, output bit rdy_hi, output bit cs_hi);
    n = 0;
    rdy_hi = 0;
    cs_hi = 0;
    while (!out_valid && n < 1000) begin
      if (in_ready) rdy_hi = 1;
      if (spi_cs_n) cs_hi = 1;
      step();
      n++;
    end
    if (!out_valid) chk("out_valid_seen", out_valid, 1);
  endtask

  task automatic wait_cs_high(output int n);
    n = 0;
    while (!spi_cs_n && n < 1000) begin
      step();
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [1:0] mode;
    logic       cbit;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vt[4];

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises, highs;
    bit r_hi, c_hi, seen;
    logic prev;
    logic [7:0] bits, rb;

    vt[0] = '{tx: 8'hA5, mode: 2'd0, cbit: 1'b0, exp_rx: 8'hA5};
    vt[1] = '{tx: 8'h00, mode: 2'd1, cbit: 1'b1, exp_rx: 8'hFF};
    vt[2] = '{tx: 8'hFF, mode: 2'd1, cbit: 1'b0, exp_rx: 8'h00};
    vt[3] = '{tx: 8'h69, mode: 2'd0, cbit: 1'b0, exp_rx: 8'h69};

    repeat (3) step();
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_sclk", spi_sclk, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_b_cs_n", b_cs_n, 1);
    rst = 1'b1;
    repeat (2) step();

    // Single bytes from IDLE: timing, data, in_ready/cs_n while shifting, cs_n release.
    for (int i = 0; i < 4; i++) begin
      miso_mode  = vt[i].mode;
      miso_const = vt[i].cbit;
      send(vt[i].tx);
      chk("cs_low_after_accept", spi_cs_n, 0);
      wait_ov(n, r_hi, c_hi);
      chk("first_byte_cycles", n, T_FIRST);
      chk("in_ready_low_lead_shift", r_hi, 0);
      chk("cs_low_lead_shift", c_hi, 0);
      chk("out_data_vec", out_data, vt[i].exp_rx);
      chk("in_ready_hold", in_ready, 1);
      step();
      chk("out_valid_one_cycle", out_valid, 0);
      wait_cs_high(n);
      chk("cs_hold_cycles", n + 1, CS_HOLD);
      chk("idle_not_busy", busy, 0);
      repeat (3) step();
    end

    // Back-to-back: second byte offered in HOLD goes straight to SHIFT.
    miso_mode = 2'd0;
    send(8'h3C);
    wait_ov(n, r_hi, c_hi);
    chk("b2b_first_cycles", n, T_FIRST);
    chk("b2b_first_data", out_data, 8'h3C);
    send(8'hC3);
    chk("b2b_cs_low", spi_cs_n, 0);
    wait_ov(n, r_hi, c_hi);
    chk("b2b_second_cycles_no_lead", n, T_NEXT);
    chk("b2b_cs_never_high", c_hi, 0);
    chk("b2b_second_data", out_data, 8'hC3);
    wait_cs_high(n);
    repeat (2) step();

    // Offer exactly on the HOLD timeout cycle: transfer wins, cs_n stays low.
    send(8'h81);
    wait_ov(n, r_hi, c_hi);
    repeat (CS_HOLD - 1) step();
    chk("timeout_cycle_ready", in_ready, 1);
    send(8'h7E);
    chk("timeout_cs_low", spi_cs_n, 0);
    wait_ov(n, r_hi, c_hi);
    chk("timeout_no_lead_cycles", n, T_NEXT);
    chk("timeout_cs_never_high", c_hi, 0);
    chk("timeout_data", out_data, 8'h7E);
    wait_cs_high(n);
    repeat (2) step();

    // Reset on the third rising SCLK edge aborts the byte.
    send(8'hB4);
    rises = 0;
    n = 0;
    prev = spi_sclk;
    while (rises < 3 && n < 500) begin
      step();
      n++;
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
    chk("abort_third_rise_seen", rises, 3);
    rst = 1'b0;
    step();
    chk("abort_cs_n", spi_cs_n, 1);
    chk("abort_sclk", spi_sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid || !spi_cs_n) seen = 1;
      step();
    end
    chk("abort_quiet", seen, 0);
    send(8'h96);
    wait_ov(n, r_hi, c_hi);
    chk("after_abort_cycles", n, T_FIRST);
    chk("after_abort_data", out_data, 8'h96);
    wait_cs_high(n);
    repeat (2) step();

    // Random bytes, random MISO, random gaps around the CS_HOLD boundary.
    miso_mode = 2'd2;
    send(8'($urandom));
    wait_ov(n, r_hi, c_hi);
    chk("rand_first_cycles", n, T_FIRST);
    for (int i = 0; i < 24; i++) begin
      int gap;
      gap = $urandom_range(0, CS_HOLD + 3);
      repeat (gap) step();
      chk("rand_cs_state", spi_cs_n, (gap >= CS_HOLD) ? 1 : 0);
      send(8'($urandom));
      wait_ov(n, r_hi, c_hi);
      chk("rand_cycles", n, (gap >= CS_HOLD) ? T_FIRST : T_NEXT);
      chk("rand_in_ready_low", r_hi, 0);
    end
    wait_cs_high(n);
    chk("rand_cs_release", n, CS_HOLD);
    chk("rand_all_bytes_returned", tx_q.size(), 0);

    // Fast build: CLK_DIV=1, CS_HOLD=1, CS_LEAD=1.
    b_in_data  = 8'h5A;
    b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 100) begin
      step();
      n++;
    end
    step();
    b_in_valid = 1'b0;
    chk("fast_cs_low", b_cs_n, 0);
    n = 0;
    rises = 0;
    highs = 0;
    bits = '0;
    prev = b_sclk;
    while (!b_out_valid && n < 200) begin
      step();
      n++;
      if (b_sclk) highs++;
      if (b_sclk && !prev) begin
        rises++;
        bits = {bits[6:0], b_mosi};
      end
      prev = b_sclk;
    end
    rb = b_out_data;
    chk("fast_byte_cycles", n, 1 + 16);
    chk("fast_rises", rises, 8);
    chk("fast_high_cycles", highs, 8);
    chk("fast_mosi_bits", bits, 8'h5A);
    chk("fast_out_data", rb, 8'h5A);
    step();
    chk("fast_cs_release", b_cs_n, 1);
    chk("fast_out_valid_pulse", b_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
